// File: rtl/cross_bar_bank_arbiter.sv
// Per-bank request arbiter: round-robin grant of channels 0..2 onto one bank HTU port,
// with a one-entry registered output stage, per-channel read credits and rob slot allocation.
module cross_bar_bank_arbiter #(
    parameter int BANK_ID    = 0,
    parameter int MAX_RD_OUT = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [2:0]   ch_req_valid_i,
    output logic [2:0]   ch_req_allowIn_o,
    input  logic [5:0]   ch_req_op_i,
    input  logic [83:0]  ch_req_addr_i,
    input  logic [383:0] ch_req_data_i,
    input  logic [2:0]   ch_rd_pop_i,
    output logic         htu_valid_o,
    input  logic         htu_allowIn_i,
    output logic [1:0]   htu_ch_id_o,
    output logic [1:0]   htu_opcode_o,
    output logic [27:0]  htu_addr_o,
    output logic [127:0] htu_data_o,
    output logic [2:0]   htu_rob_num_o,
    output logic         credit_err_o
);

    localparam logic [1:0] OP_READ = 2'b00;

    logic [1:0]   op_c   [3];
    logic [27:0]  addr_c [3];
    logic [127:0] data_c [3];
    logic [3:0]   rd_cnt [3];
    logic [2:0]   rob_ptr[3];
    logic [1:0]   rr_ptr;

    logic [2:0] elig;
    logic [2:0] gnt;
    logic [2:0] rd_gnt;
    logic [1:0] gnt_id;
    logic       gnt_any;
    logic       load_en;

    // Line-address field holds addr[31:4], so bank select addr[9:8] is field bits [5:4].
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            op_c[c]   = ch_req_op_i[c*2 +: 2];
            addr_c[c] = ch_req_addr_i[c*28 +: 28];
            data_c[c] = ch_req_data_i[c*128 +: 128];
            elig[c]   = ch_req_valid_i[c] && (addr_c[c][5:4] == 2'(BANK_ID)) &&
                        ((op_c[c] != OP_READ) || (rd_cnt[c] < 4'(MAX_RD_OUT)));
        end
    end

    always_comb begin
        load_en = ~htu_valid_o | htu_allowIn_i;
        gnt_any = 1'b0;
        gnt_id  = 2'd0;
        for (int k = 0; k < 3; k++) begin
            int idx;
            idx = int'(rr_ptr) + k;
            if (idx >= 3) idx = idx - 3;
            if (!gnt_any && elig[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = 2'(idx);
            end
        end
        // Nothing is accepted while the output register is held or reset is asserted.
        if (!load_en || !rst_i) gnt_any = 1'b0;
        gnt = gnt_any ? (3'b001 << gnt_id) : 3'b000;
        for (int c = 0; c < 3; c++) begin
            rd_gnt[c] = gnt[c] && (op_c[c] == OP_READ);
        end
    end

    assign ch_req_allowIn_o = gnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            htu_valid_o   <= 1'b0;
            htu_ch_id_o   <= '0;
            htu_opcode_o  <= '0;
            htu_addr_o    <= '0;
            htu_data_o    <= '0;
            htu_rob_num_o <= '0;
            credit_err_o  <= 1'b0;
            rr_ptr        <= '0;
            for (int c = 0; c < 3; c++) begin
                rd_cnt[c]  <= '0;
                rob_ptr[c] <= '0;
            end
        end else begin
            if (load_en) htu_valid_o <= gnt_any;
            if (gnt_any) begin
                htu_ch_id_o   <= gnt_id;
                htu_opcode_o  <= op_c[gnt_id];
                htu_addr_o    <= addr_c[gnt_id];
                htu_data_o    <= data_c[gnt_id];
                htu_rob_num_o <= (op_c[gnt_id] == OP_READ) ? rob_ptr[gnt_id] : 3'd0;
                rr_ptr        <= (gnt_id == 2'd2) ? 2'd0 : gnt_id + 2'd1;
            end
            // A pop with nothing outstanding is an upstream bug: flag it and clamp at zero.
            for (int c = 0; c < 3; c++) begin
                if (rd_gnt[c]) rob_ptr[c] <= rob_ptr[c] + 3'd1;
                if (ch_rd_pop_i[c] && rd_cnt[c] == 4'd0) begin
                    credit_err_o <= 1'b1;
                    rd_cnt[c]    <= {3'b000, rd_gnt[c]};
                end else begin
                    rd_cnt[c] <= rd_cnt[c] + {3'b000, rd_gnt[c]} - {3'b000, ch_rd_pop_i[c]};
                end
            end
        end
    end

endmodule

// File: tb/tb_cross_bar_bank_arbiter.sv
// Directed bench for cross_bar_bank_arbiter (BANK_ID=0, MAX_RD_OUT=8) with an expected-transaction
// queue filled at accept time and drained when the HTU output register updates.
module tb_cross_bar_bank_arbiter;

    typedef struct packed {
        logic [1:0]   ch;
        logic [1:0]   op;
        logic [27:0]  addr;
        logic [127:0] data;
        logic [2:0]   rob;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_i;
    logic [2:0]   valid_v;
    logic [2:0]   allow;
    logic [5:0]   op_v;
    logic [83:0]  addr_v;
    logic [383:0] data_v;
    logic [2:0]   pop_v;
    logic         htu_valid;
    logic         hallow;
    logic [1:0]   htu_ch;
    logic [1:0]   htu_op;
    logic [27:0]  htu_addr;
    logic [127:0] htu_data;
    logic [2:0]   htu_rob;
    logic         cerr;

    int   passes = 0;
    int   total  = 0;
    exp_t q[$];
    exp_t last;

    int   m_rr;
    int   m_cnt[3];
    int   m_rob[3];
    int   m_bank[3];
    bit   m_vld;
    bit   m_err;

    cross_bar_bank_arbiter #(.BANK_ID(0), .MAX_RD_OUT(8)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .ch_req_valid_i(valid_v), .ch_req_allowIn_o(allow),
        .ch_req_op_i(op_v), .ch_req_addr_i(addr_v), .ch_req_data_i(data_v),
        .ch_rd_pop_i(pop_v),
        .htu_valid_o(htu_valid), .htu_allowIn_i(hallow),
        .htu_ch_id_o(htu_ch), .htu_opcode_o(htu_op), .htu_addr_o(htu_addr),
        .htu_data_o(htu_data), .htu_rob_num_o(htu_rob), .credit_err_o(cerr)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_rr = 0; m_vld = 0; m_err = 0;
        for (int c = 0; c < 3; c++) begin
            m_cnt[c] = 0;
            m_rob[c] = 0;
        end
        q.delete();
    endtask

    task automatic set_ch(int c, logic v, logic [1:0] o, logic [1:0] bank);
        logic [31:0] fa;
        fa = ($urandom & 32'hFFFF_FC00) | (32'(bank) << 8) | (32'(c) << 4);
        valid_v[c]           = v;
        op_v[c*2 +: 2]       = o;
        addr_v[c*28 +: 28]   = fa[31:4];
        data_v[c*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
        m_bank[c]            = int'(bank);
    endtask

    // One clock: predict the grant, check the handshake, then check the registered output.
    task automatic cyc();
        int         g;
        bit         le;
        bit         rg;
        logic [2:0] ea;
        exp_t       e;
        #1;
        le = !m_vld || hallow;
        g  = -1;
        for (int k = 0; k < 3; k++) begin
            int idx;
            idx = (m_rr + k) % 3;
            if (g < 0 && le && valid_v[idx] && m_bank[idx] == 0 &&
                (op_v[idx*2 +: 2] != 2'b00 || m_cnt[idx] < 8)) g = idx;
        end
        ea = (g >= 0) ? (3'b001 << g) : 3'b000;
        chk("allowIn", 128'(allow), 128'(ea));
        if (g >= 0) begin
            e.ch   = 2'(g);
            e.op   = op_v[g*2 +: 2];
            e.addr = addr_v[g*28 +: 28];
            e.data = data_v[g*128 +: 128];
            e.rob  = (e.op == 2'b00) ? 3'(m_rob[g]) : 3'd0;
            q.push_back(e);
        end
        for (int c = 0; c < 3; c++) begin
            rg = (g == c) && (op_v[c*2 +: 2] == 2'b00);
            if (pop_v[c] && m_cnt[c] == 0) begin
                m_err    = 1;
                m_cnt[c] = int'(rg);
            end else begin
                m_cnt[c] = m_cnt[c] + int'(rg) - int'(pop_v[c]);
            end
            if (rg) m_rob[c] = (m_rob[c] + 1) % 8;
        end
        if (le) m_vld = (g >= 0);
        if (g >= 0) m_rr = (g + 1) % 3;
        @(posedge clk);
        #1;
        if (g >= 0) begin
            e    = q.pop_front();
            last = e;
        end
        if (m_vld) begin
            chk("htu_ch_id", 128'(htu_ch), 128'(last.ch));
            chk("htu_opcode", 128'(htu_op), 128'(last.op));
            chk("htu_addr", 128'(htu_addr), 128'(last.addr));
            chk("htu_data", htu_data, last.data);
            chk("htu_rob_num", 128'(htu_rob), 128'(last.rob));
        end
        chk("htu_valid", 128'(htu_valid), 128'(m_vld));
        chk("credit_err", 128'(cerr), 128'(m_err));
        @(negedge clk);
    endtask

    task automatic drain_credits();
        valid_v = '0;
        for (int n = 0; n < 10; n++) begin
            for (int c = 0; c < 3; c++) pop_v[c] = (m_cnt[c] > 0);
            if (pop_v != 3'b000) cyc();
        end
        pop_v = '0;
    endtask

    initial begin
        rst_i = 1'b0; hallow = 1'b1;
        valid_v = '0; op_v = '0; addr_v = '0; data_v = '0; pop_v = '0;
        for (int c = 0; c < 3; c++) m_bank[c] = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 128'(htu_valid), 128'(0));
        chk("rst_allow", 128'(allow), 128'(0));
        chk("rst_payload", {htu_ch, htu_op, htu_addr, htu_rob}, 128'(0));
        chk("rst_data", htu_data, 128'(0));
        chk("rst_err", 128'(cerr), 128'(0));
        @(negedge clk);
        rst_i = 1'b1;

        // All channels reading back to back: ch 0,1,2,0,1,2 with per-channel rob 0,0,0,1,1,1.
        for (int c = 0; c < 3; c++) set_ch(c, 1'b1, 2'b00, 2'd0);
        repeat (6) cyc();

        // Asynchronous reset in the middle of the burst.
        #2 rst_i = 1'b0;
        #1;
        chk("midrst_valid", 128'(htu_valid), 128'(0));
        chk("midrst_allow", 128'(allow), 128'(0));
        model_reset();
        @(negedge clk);
        rst_i = 1'b1;
        cyc();
        chk("post_rst_first_ch", 128'(htu_ch), 128'(0));
        drain_credits();
        cyc();

        // ch1 fills its 8 read credits; rob slots wrap.
        set_ch(1, 1'b1, 2'b00, 2'd0);
        repeat (8) cyc();
        set_ch(0, 1'b1, 2'b00, 2'd0);
        repeat (2) cyc();
        set_ch(1, 1'b1, 2'b01, 2'd0);
        cyc();
        valid_v[0] = 1'b0;
        set_ch(1, 1'b1, 2'b00, 2'd0);
        pop_v = 3'b010;
        cyc();
        pop_v = 3'b000;
        cyc();
        chk("wrap_rob_num", 128'(htu_rob), 128'(0));

        // Grant and pop on the same channel in the same cycle leave the count unchanged.
        valid_v = '0;
        pop_v = 3'b010;
        cyc();
        set_ch(1, 1'b1, 2'b00, 2'd0);
        cyc();
        pop_v = 3'b000;
        repeat (3) cyc();
        valid_v = '0;
        repeat (2) cyc();
        drain_credits();

        // Backpressure: output held for 5 cycles, then back-to-back grants on release.
        set_ch(0, 1'b1, 2'b00, 2'd0);
        set_ch(2, 1'b1, 2'b10, 2'd0);
        cyc();
        hallow = 1'b0;
        repeat (5) cyc();
        hallow = 1'b1;
        repeat (3) cyc();
        valid_v = '0;
        cyc();
        drain_credits();

        // Wrong bank never granted; pop with nothing outstanding sets the sticky error.
        set_ch(2, 1'b1, 2'b01, 2'd2);
        repeat (3) cyc();
        pop_v = 3'b001;
        cyc();
        pop_v = 3'b000;
        chk("credit_err_set", 128'(cerr), 128'(1));
        set_ch(0, 1'b1, 2'b00, 2'd0);
        repeat (9) cyc();
        valid_v = '0;
        cyc();
        drain_credits();
        cyc();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
